// File: rtl/weight_packer_if.sv
// Beat-in / word-out bundle between the weight feeder and its neighbours.
// The master side drives beats and load requests; the slave side is the packer.
interface weight_packer_if #(
  parameter int DW    = 9,
  parameter int LANES = 4
);
  localparam int WW = DW * LANES;

  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_ready;
  logic          i_load_req;
  logic          i_clear;
  logic [WW-1:0] o_weight;
  logic          o_en;
  logic          o_pending;

  modport master (
    output i_valid, i_data, i_load_req, i_clear,
    input  o_ready, o_weight, o_en, o_pending
  );

  modport slave (
    input  i_valid, i_data, i_load_req, i_clear,
    output o_ready, o_weight, o_en, o_pending
  );
endinterface

// File: rtl/weight_packer.sv
// Packs LANES beats into one word, buffers DEPTH words, and on request pops the head
// into o_weight with a one-cycle o_en (request to o_en: 1 cycle; o_ready low while the buffer is full).
module weight_packer #(
  parameter int DW    = 9,
  parameter int LANES = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  weight_packer_if.slave   bus
);
  localparam int WW = DW * LANES;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(LANES);

  typedef logic [LANES-1:0][DW-1:0] word_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [LW-1:0] r_lane;
  word_t         r_part;
  word_t         w_word;
  word_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  word_t         r_weight;

  logic w_ready;
  logic w_have;
  logic w_last;
  logic w_accept;
  logic w_push;
  logic w_pop;

  assign w_ready  = (r_count < CW'(DEPTH));
  assign w_have   = (r_count != '0);
  assign w_last   = (r_lane == LW'(LANES - 1));
  assign w_accept = bus.i_valid & w_ready & ~bus.i_clear;
  assign w_push   = w_accept & w_last;
  // Pop is tied to the transition into ISSUE, so o_weight only moves on that edge.
  assign w_pop    = (w_next == S_ISSUE);

  always_comb begin
    w_word          = r_part;
    w_word[LANES-1] = bus.i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane <= '0;
      r_part <= '0;
    end else if (bus.i_clear) begin
      r_lane <= '0;
    end else if (w_accept) begin
      r_part[r_lane] <= bus.i_data;
      r_lane         <= w_last ? '0 : r_lane + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (bus.i_clear) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
      r_wr_ptr        <= r_wr_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
    end else if (bus.i_clear) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (bus.i_clear) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Count is the registered value, so a word pushed this edge is not visible to the FSM until next cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_load_req) w_next = w_have ? S_ISSUE : S_WAIT;
      S_WAIT:  if (w_have) w_next = S_ISSUE;
      S_ISSUE: begin
        if (bus.i_load_req) w_next = w_have ? S_ISSUE : S_WAIT;
        else                w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (bus.i_clear) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_weight <= '0;
    else if (w_pop) r_weight <= r_mem[r_rd_ptr];
  end

  assign bus.o_ready   = w_ready;
  assign bus.o_weight  = WW'(r_weight);
  assign bus.o_en      = (r_state == S_ISSUE);
  assign bus.o_pending = (r_state == S_WAIT);
endmodule

// File: tb/tb_weight_packer.sv
// Directed and random bench for weight_packer; a queue-level model predicts o_en, o_pending,
// o_weight and o_ready after every clock edge.
module tb_weight_packer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  weight_packer_if #(.DW(9), .LANES(4)) u_if ();

  weight_packer #(.DW(9), .LANES(4), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  logic [35:0] m_q [$];
  logic [35:0] m_part;
  int          m_lane;
  bit          m_pend;
  bit          m_en;
  logic [35:0] m_wt;

  logic [35:0] w1, w2, w3, w4, w5;

  function automatic logic [35:0] pk(input logic [8:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_part = '0;
    m_lane = 0;
    m_pend = 1'b0;
    m_en   = 1'b0;
    m_wt   = '0;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
  task automatic cyc(input bit v, input logic [8:0] d, input bit req, input bit clr);
    bit rdy;
    bit want;
    u_if.i_valid    = v;
    u_if.i_data     = d;
    u_if.i_load_req = req;
    u_if.i_clear    = clr;
    rdy = (m_q.size() < 2);
    @(posedge clk);
    if (clr) begin
      m_q.delete();
      m_part = '0;
      m_lane = 0;
      m_pend = 1'b0;
      m_en   = 1'b0;
    end else begin
      want = m_pend | req;
      if (want && m_q.size() > 0) begin
        m_wt   = m_q.pop_front();
        m_en   = 1'b1;
        m_pend = 1'b0;
      end else begin
        m_en   = 1'b0;
        m_pend = want;
      end
      if (v && rdy) begin
        m_part[m_lane*9 +: 9] = d;
        if (m_lane == 3) begin
          m_q.push_back(m_part);
          m_part = '0;
          m_lane = 0;
        end else begin
          m_lane++;
        end
      end
    end
    #1;
    chk("o_en",      u_if.o_en,      m_en);
    chk("o_pending", u_if.o_pending, m_pend);
    chk("o_weight",  u_if.o_weight,  m_wt);
    chk("o_ready",   u_if.o_ready,   (m_q.size() < 2));
  endtask

  task automatic feed_word(input logic [8:0] b0, b1, b2, b3);
    cyc(1'b1, b0, 1'b0, 1'b0);
    cyc(1'b1, b1, 1'b0, 1'b0);
    cyc(1'b1, b2, 1'b0, 1'b0);
    cyc(1'b1, b3, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n           = 1'b0;
    u_if.i_valid    = 1'b0;
    u_if.i_data     = '0;
    u_if.i_load_req = 1'b0;
    u_if.i_clear    = 1'b0;
    model_reset();
    w1 = pk(9'h011, 9'h012, 9'h013, 9'h014);
    w2 = pk(9'h021, 9'h022, 9'h023, 9'h024);
    w3 = pk(9'h031, 9'h032, 9'h033, 9'h034);
    w4 = pk(9'h051, 9'h052, 9'h053, 9'h054);
    w5 = pk(9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4);

    #7;
    chk("reset_weight",  u_if.o_weight,  36'h0);
    chk("reset_en",      u_if.o_en,      36'h0);
    chk("reset_pending", u_if.o_pending, 36'h0);
    chk("reset_ready",   u_if.o_ready,   36'h1);
    #5 rst_n = 1'b1;

    // Basic pack and issue, one-cycle request latency.
    feed_word(9'h001, 9'h002, 9'h003, 9'h004);
    cyc(1'b0, 9'h0, 1'b1, 1'b0);
    chk("t1_en",     u_if.o_en,     36'h1);
    chk("t1_weight", u_if.o_weight, 36'h0200C0401);
    cyc(1'b0, 9'h0, 1'b0, 1'b0);
    chk("t1_en_one_cycle", u_if.o_en, 36'h0);

    // Starved request, coalesced second request, then issue after the word lands.
    cyc(1'b0, 9'h0, 1'b1, 1'b0);
    chk("t2_pending", u_if.o_pending, 36'h1);
    cyc(1'b1, 9'h011, 1'b0, 1'b0);
    cyc(1'b1, 9'h012, 1'b1, 1'b0);
    cyc(1'b1, 9'h013, 1'b0, 1'b0);
    cyc(1'b1, 9'h014, 1'b0, 1'b0);
    chk("t2_no_bypass_en",  u_if.o_en,      36'h0);
    chk("t2_still_pending", u_if.o_pending, 36'h1);
    cyc(1'b0, 9'h0, 1'b0, 1'b0);
    chk("t2_en",         u_if.o_en,      36'h1);
    chk("t2_pend_drop",  u_if.o_pending, 36'h0);
    chk("t2_weight",     u_if.o_weight,  w1);
    cyc(1'b0, 9'h0, 1'b0, 1'b0);
    chk("t2_single_en",  u_if.o_en,      36'h0);

    // Fill the buffer, stall the third word, one pop reopens o_ready.
    feed_word(9'h011, 9'h012, 9'h013, 9'h014);
    feed_word(9'h021, 9'h022, 9'h023, 9'h024);
    chk("t3_full_ready", u_if.o_ready, 36'h0);
    cyc(1'b1, 9'h031, 1'b0, 1'b0);
    cyc(1'b1, 9'h031, 1'b0, 1'b0);
    cyc(1'b1, 9'h031, 1'b1, 1'b0);
    chk("t3_reopen_ready", u_if.o_ready,  36'h1);
    chk("t3_pop_w1",       u_if.o_weight, w1);
    feed_word(9'h031, 9'h032, 9'h033, 9'h034);

    // Back-to-back requests drain in FIFO order.
    cyc(1'b0, 9'h0, 1'b1, 1'b0);
    chk("t4_en_a",     u_if.o_en,     36'h1);
    chk("t4_weight_a", u_if.o_weight, w2);
    cyc(1'b0, 9'h0, 1'b1, 1'b0);
    chk("t4_en_b",     u_if.o_en,     36'h1);
    chk("t4_weight_b", u_if.o_weight, w3);
    cyc(1'b0, 9'h0, 1'b0, 1'b0);

    // Clear drops a partial word, a pending request and a beat in the clear cycle.
    cyc(1'b1, 9'h041, 1'b0, 1'b0);
    cyc(1'b1, 9'h042, 1'b0, 1'b0);
    cyc(1'b0, 9'h0, 1'b1, 1'b0);
    chk("t5_pending_before", u_if.o_pending, 36'h1);
    cyc(1'b1, 9'h1FF, 1'b1, 1'b1);
    chk("t5_pending_cleared", u_if.o_pending, 36'h0);
    chk("t5_no_en",           u_if.o_en,      36'h0);
    chk("t5_weight_kept",     u_if.o_weight,  w3);
    feed_word(9'h051, 9'h052, 9'h053, 9'h054);
    cyc(1'b0, 9'h0, 1'b1, 1'b0);
    chk("t5_fresh_word", u_if.o_weight, w4);
    cyc(1'b0, 9'h0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(3) != 0), 9'($urandom), ($urandom_range(4) == 0), ($urandom_range(63) == 0));
    end
    cyc(1'b0, 9'h0, 1'b0, 1'b1);

    // Async reset while in ISSUE with a partial word outstanding.
    feed_word(9'h061, 9'h062, 9'h063, 9'h064);
    cyc(1'b1, 9'h071, 1'b0, 1'b0);
    cyc(1'b1, 9'h072, 1'b0, 1'b0);
    cyc(1'b0, 9'h0, 1'b1, 1'b0);
    chk("t6_in_issue", u_if.o_en, 36'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_en",      u_if.o_en,      36'h0);
    chk("t6_rst_weight",  u_if.o_weight,  36'h0);
    chk("t6_rst_pending", u_if.o_pending, 36'h0);
    chk("t6_rst_ready",   u_if.o_ready,   36'h1);
    model_reset();
    #3 rst_n = 1'b1;
    feed_word(9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4);
    cyc(1'b0, 9'h0, 1'b1, 1'b0);
    chk("t6_post_reset_word", u_if.o_weight, w5);
    cyc(1'b0, 9'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
